// File: rtl/dds_seq_pkg.sv
// Shared definitions for the DDS sweep sequencer: reserved-code offsets,
// CTRL bit positions, FSM state encoding and default tuning command codes.
package dds_seq_pkg;

   localparam logic [2:0] OFS_START = 3'd0;
   localparam logic [2:0] OFS_STOP  = 3'd1;
   localparam logic [2:0] OFS_STEP  = 3'd2;
   localparam logic [2:0] OFS_IVL   = 3'd3;
   localparam logic [2:0] OFS_CTRL  = 3'd4;

   localparam int CTRL_RUN  = 0;
   localparam int CTRL_TGT  = 1;
   localparam int CTRL_LOOP = 2;

   localparam logic [7:0] DEF_TUNE0_CMD = 8'h01;
   localparam logic [7:0] DEF_TUNE1_CMD = 8'h02;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_e;

endpackage

// File: rtl/dds_sweep_sequencer_timer.sv
// Loadable down-counter that paces sweep steps; expire pulses for one cycle
// while the count sits at one, i.e. the cycle before it reaches zero.
module seq_step_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expire
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] cnt_r;
   logic [W-1:0] cnt_s;
   logic         expire_r;

   // Next count: clear wins over load, otherwise count down and park at zero
   always_comb begin
      cnt_s = cnt_r;
      if (clr) begin
         cnt_s = '0;
      end else if (load) begin
         cnt_s = load_val;
      end else if (cnt_r != '0) begin
         cnt_s = cnt_r - ONE;
      end else begin
         cnt_s = cnt_r;
      end
   end

   // Count register and registered expire strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r    <= '0;
         expire_r <= 1'b0;
      end else begin
         cnt_r    <= cnt_s;
         expire_r <= (cnt_s == ONE);
      end
   end

   assign expire = expire_r;

endmodule

// File: rtl/dds_sweep_sequencer.sv
// Linear tuning-word sweep generator that shares the decoder command port
// with SPI passthrough traffic; passthrough always wins the port.
module dds_sweep_sequencer
   import dds_seq_pkg::*;
#(
   parameter int               CMD_W     = 8,
   parameter int               DATA_W    = 16,
   parameter int               IVL_W     = 16,
   parameter logic [CMD_W-1:0] TUNE0_CMD = CMD_W'(DEF_TUNE0_CMD),
   parameter logic [CMD_W-1:0] TUNE1_CMD = CMD_W'(DEF_TUNE1_CMD),
   parameter logic [CMD_W-1:0] SEQ_BASE  = CMD_W'(8'hC0)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CMD_W-1:0]  in_cmd_word,
   input  logic [DATA_W-1:0] in_data_word,
   input  logic              in_cmd_valid,
   output logic [CMD_W-1:0]  out_cmd_word,
   output logic [DATA_W-1:0] out_data_word,
   output logic              out_cmd_valid,
   output logic              sweep_active,
   output logic [DATA_W-1:0] cur_tune
);

   logic [CMD_W-1:0]  ofs_s;
   logic              rsv_s, pass_s, cfg_ctrl_s, abort_s, run_req_s;
   logic [DATA_W-1:0] start_r, stop_r, step_r;
   logic [IVL_W-1:0]  ivl_r;
   logic              tgt_r, loop_r;
   seq_state_e        state_r, state_s;
   logic [DATA_W-1:0] cur_r, cur_s, next_s;
   logic [DATA_W:0]   sum_s, dif_s;
   logic              grant_s, tmr_load_s, tmr_clr_s, tmr_expire_s;
   logic [IVL_W-1:0]  tmr_val_s;
   logic              active_r, out_valid_r;
   logic [CMD_W-1:0]  out_cmd_r;
   logic [DATA_W-1:0] out_data_r, cur_tune_r;

   // Classify the incoming strobe; the offset subtraction makes the range test one compare
   always_comb begin
      ofs_s      = in_cmd_word - SEQ_BASE;
      rsv_s      = in_cmd_valid & (ofs_s <= CMD_W'(3'd4));
      pass_s     = in_cmd_valid & ~rsv_s;
      cfg_ctrl_s = rsv_s & (ofs_s[2:0] == OFS_CTRL);
      abort_s    = cfg_ctrl_s & ~in_data_word[CTRL_RUN];
      run_req_s  = cfg_ctrl_s & in_data_word[CTRL_RUN];
   end

   // Configuration registers written by the reserved codes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_r <= '0;
         stop_r  <= '0;
         step_r  <= '0;
         ivl_r   <= '0;
         tgt_r   <= 1'b0;
         loop_r  <= 1'b0;
      end else if (rsv_s) begin
         case (ofs_s[2:0])
            OFS_START: start_r <= in_data_word;
            OFS_STOP:  stop_r  <= in_data_word;
            OFS_STEP:  step_r  <= in_data_word;
            OFS_IVL:   ivl_r   <= in_data_word[IVL_W-1:0];
            OFS_CTRL: begin
               tgt_r  <= in_data_word[CTRL_TGT];
               loop_r <= in_data_word[CTRL_LOOP];
            end
            default:   start_r <= start_r;
         endcase
      end
   end

   // Next tuning word, one bit wider so overflow and underflow clamp to STOP
   always_comb begin
      sum_s = {1'b0, cur_r} + {1'b0, step_r};
      dif_s = {1'b0, cur_r} - {1'b0, step_r};
      if (start_r <= stop_r) begin
         if (sum_s > {1'b0, stop_r}) begin
            next_s = stop_r;
         end else begin
            next_s = sum_s[DATA_W-1:0];
         end
      end else begin
         if (dif_s[DATA_W] || (dif_s[DATA_W-1:0] < stop_r)) begin
            next_s = stop_r;
         end else begin
            next_s = dif_s[DATA_W-1:0];
         end
      end
      // ISSUE itself takes a cycle, so WAIT is one shorter than the write period
      tmr_val_s = (ivl_r > IVL_W'(2'd2)) ? ivl_r - IVL_W'(1'b1) : IVL_W'(1'b1);
   end

   // Sweep FSM next state; abort overrides everything, including a pending grant
   always_comb begin
      state_s    = state_r;
      cur_s      = cur_r;
      grant_s    = 1'b0;
      tmr_load_s = 1'b0;
      tmr_clr_s  = 1'b0;
      if (abort_s) begin
         state_s   = ST_IDLE;
         tmr_clr_s = 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (run_req_s) begin
                  state_s = ST_ISSUE;
                  cur_s   = start_r;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_ISSUE: begin
               if (!pass_s) begin
                  grant_s = 1'b1;
                  if (step_r == '0) begin
                     state_s = ST_IDLE;
                  end else if (cur_r == stop_r) begin
                     state_s = ST_DONE;
                  end else begin
                     state_s    = ST_WAIT;
                     tmr_load_s = 1'b1;
                  end
               end else begin
                  state_s = ST_ISSUE;
               end
            end
            ST_WAIT: begin
               if (tmr_expire_s) begin
                  state_s = ST_ISSUE;
                  cur_s   = next_s;
               end else begin
                  state_s = ST_WAIT;
               end
            end
            ST_DONE: begin
               if (loop_r) begin
                  state_s = ST_ISSUE;
                  cur_s   = start_r;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            default: state_s = ST_IDLE;
         endcase
      end
   end

   // FSM state, working tuning word and activity flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         cur_r    <= '0;
         active_r <= 1'b0;
      end else begin
         state_r  <= state_s;
         cur_r    <= cur_s;
         active_r <= (state_s != ST_IDLE);
      end
   end

   // Decoder port: passthrough first, sweep write only when the port is free
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_cmd_r   <= '0;
         out_data_r  <= '0;
         cur_tune_r  <= '0;
      end else begin
         out_valid_r <= pass_s | grant_s;
         if (pass_s) begin
            out_cmd_r  <= in_cmd_word;
            out_data_r <= in_data_word;
         end else if (grant_s) begin
            out_cmd_r  <= tgt_r ? TUNE1_CMD : TUNE0_CMD;
            out_data_r <= cur_r;
            cur_tune_r <= cur_r;
         end
      end
   end

   seq_step_timer #(.W(IVL_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (tmr_clr_s),
      .load     (tmr_load_s),
      .load_val (tmr_val_s),
      .expire   (tmr_expire_s)
   );

   assign out_cmd_valid = out_valid_r;
   assign out_cmd_word  = out_cmd_r;
   assign out_data_word = out_data_r;
   assign sweep_active  = active_r;
   assign cur_tune      = cur_tune_r;

endmodule
